// File: rtl/sap_ctrl_pkg.sv
// Shared types and constants for the SAP fetch/execute control sequencer:
// opcodes, the state encoding and the bit layout of the control word.
package sap_ctrl_pkg;

    localparam int OP_WIDTH = 4;

    localparam logic [OP_WIDTH-1:0] OP_LDA = 4'b0000;
    localparam logic [OP_WIDTH-1:0] OP_ADD = 4'b0001;
    localparam logic [OP_WIDTH-1:0] OP_SUB = 4'b0010;
    localparam logic [OP_WIDTH-1:0] OP_OUT = 4'b1110;
    localparam logic [OP_WIDTH-1:0] OP_HLT = 4'b1111;

    // T1..T6 are encoded as their step number so TState falls straight out of the state.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_T1     = 3'd1,
        ST_T2     = 3'd2,
        ST_T3     = 3'd3,
        ST_T4     = 3'd4,
        ST_T5     = 3'd5,
        ST_T6     = 3'd6,
        ST_HALTED = 3'd7
    } state_e;

    localparam int CW_PC_CLEAR = 0;
    localparam int CW_EN_COUNT = 1;
    localparam int CW_PC_OUT   = 2;
    localparam int CW_MAR_LOAD = 3;
    localparam int CW_RAM_OUT  = 4;
    localparam int CW_IR_LOAD  = 5;
    localparam int CW_IR_OUT   = 6;
    localparam int CW_ACC_LOAD = 7;
    localparam int CW_ACC_OUT  = 8;
    localparam int CW_B_LOAD   = 9;
    localparam int CW_ALU_SUB  = 10;
    localparam int CW_ALU_OUT  = 11;
    localparam int CW_OUT_LOAD = 12;
    localparam int CW_HALT     = 13;
    localparam int CW_BUSY     = 14;
    localparam int CTRL_WIDTH  = 15;

    typedef logic [CTRL_WIDTH-1:0] ctrl_t;

    // Strobes that change datapath state; Pause suppresses exactly these.
    localparam ctrl_t LOAD_MASK = ctrl_t'((15'd1 << CW_EN_COUNT) | (15'd1 << CW_MAR_LOAD) |
                                          (15'd1 << CW_IR_LOAD)  | (15'd1 << CW_ACC_LOAD) |
                                          (15'd1 << CW_B_LOAD)   | (15'd1 << CW_OUT_LOAD));

    function automatic logic is_busy(state_e s);
        return (s != ST_IDLE) && (s != ST_HALTED);
    endfunction

endpackage

// File: rtl/sap_control_sequencer_if.sv
// Control-side signal bundle between the sequencer and the SAP datapath.
interface sap_control_sequencer_if;

    logic                               Start;
    logic                               Pause;
    logic [sap_ctrl_pkg::OP_WIDTH-1:0]  IrOpcode;
    logic                               PcClear;
    logic                               EnableCOunt;
    logic                               PcOut;
    logic                               MarLoad;
    logic                               RamOut;
    logic                               IrLoad;
    logic                               IrOut;
    logic                               AccLoad;
    logic                               AccOut;
    logic                               BLoad;
    logic                               AluSub;
    logic                               AluOut;
    logic                               OutLoad;
    logic                               Halt;
    logic                               Busy;
    logic [2:0]                         TState;

    modport master (
        input  Start, Pause, IrOpcode,
        output PcClear, EnableCOunt, PcOut, MarLoad, RamOut, IrLoad, IrOut,
               AccLoad, AccOut, BLoad, AluSub, AluOut, OutLoad, Halt, Busy, TState
    );

    modport slave (
        output Start, Pause, IrOpcode,
        input  PcClear, EnableCOunt, PcOut, MarLoad, RamOut, IrLoad, IrOut,
               AccLoad, AccOut, BLoad, AluSub, AluOut, OutLoad, Halt, Busy, TState
    );

endinterface

// File: rtl/sap_ctrl_decode.sv
// Combinational decode of (state, opcode, pause) into the SAP control word.
module sap_ctrl_decode
    import sap_ctrl_pkg::*;
(
    input  state_e                state,
    input  logic [OP_WIDTH-1:0]   opcode,
    input  logic                  pause,
    output ctrl_t                 ctrl
);

    always_comb begin
        // NOTE: default every bit first so no path through the cases can infer a latch.
        ctrl = '0;
        case (state)
            ST_IDLE:   ctrl[CW_PC_CLEAR] = 1'b1;
            ST_HALTED: ctrl[CW_HALT]     = 1'b1;
            ST_T1: begin
                ctrl[CW_PC_OUT]   = 1'b1;
                ctrl[CW_MAR_LOAD] = 1'b1;
            end
            ST_T2: ctrl[CW_EN_COUNT] = 1'b1;
            ST_T3: begin
                ctrl[CW_RAM_OUT] = 1'b1;
                ctrl[CW_IR_LOAD] = 1'b1;
            end
            ST_T4: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        ctrl[CW_IR_OUT]   = 1'b1;
                        ctrl[CW_MAR_LOAD] = 1'b1;
                    end
                    OP_OUT: begin
                        ctrl[CW_ACC_OUT]  = 1'b1;
                        ctrl[CW_OUT_LOAD] = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (opcode)
                    OP_LDA: begin
                        ctrl[CW_RAM_OUT]  = 1'b1;
                        ctrl[CW_ACC_LOAD] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl[CW_RAM_OUT] = 1'b1;
                        ctrl[CW_B_LOAD]  = 1'b1;
                        ctrl[CW_ALU_SUB] = (opcode == OP_SUB);
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    ctrl[CW_ALU_OUT]  = 1'b1;
                    ctrl[CW_ACC_LOAD] = 1'b1;
                    ctrl[CW_ALU_SUB]  = (opcode == OP_SUB);
                end
            end
            default: ;
        endcase

        ctrl[CW_BUSY] = is_busy(state);
        if (pause && is_busy(state)) begin
            ctrl = ctrl & ~LOAD_MASK;
        end
    end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP fetch/execute sequencer: T-state register and next-state logic; the
// control word comes from sap_ctrl_decode.
module sap_control_sequencer
    import sap_ctrl_pkg::*;
(
    input  logic                     MainClock,
    input  logic                     ClearCounter,
    sap_control_sequencer_if.master  bus
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.Start) state_d = ST_T1;
            ST_HALTED: state_d = ST_HALTED;
            default: begin
                if (!bus.Pause) begin
                    case (state_q)
                        ST_T1: state_d = ST_T2;
                        ST_T2: state_d = ST_T3;
                        ST_T3: state_d = ST_T4;
                        ST_T4: state_d = (bus.IrOpcode == OP_HLT) ? ST_HALTED : ST_T5;
                        ST_T5: state_d = ST_T6;
                        default: state_d = ST_T1;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge MainClock) begin
        // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
        if (ClearCounter) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    sap_ctrl_decode u_decode (
        .state  (state_q),
        .opcode (bus.IrOpcode),
        .pause  (bus.Pause),
        .ctrl   (ctrl)
    );

    assign bus.PcClear     = ctrl[CW_PC_CLEAR];
    assign bus.EnableCOunt = ctrl[CW_EN_COUNT];
    assign bus.PcOut       = ctrl[CW_PC_OUT];
    assign bus.MarLoad     = ctrl[CW_MAR_LOAD];
    assign bus.RamOut      = ctrl[CW_RAM_OUT];
    assign bus.IrLoad      = ctrl[CW_IR_LOAD];
    assign bus.IrOut       = ctrl[CW_IR_OUT];
    assign bus.AccLoad     = ctrl[CW_ACC_LOAD];
    assign bus.AccOut      = ctrl[CW_ACC_OUT];
    assign bus.BLoad       = ctrl[CW_B_LOAD];
    assign bus.AluSub      = ctrl[CW_ALU_SUB];
    assign bus.AluOut      = ctrl[CW_ALU_OUT];
    assign bus.OutLoad     = ctrl[CW_OUT_LOAD];
    assign bus.Halt        = ctrl[CW_HALT];
    assign bus.Busy        = ctrl[CW_BUSY];
    assign bus.TState      = is_busy(state_q) ? 3'(state_q) : 3'd0;

    // A shared bus: two simultaneous drivers would be a short on real hardware.
    assert property (@(posedge MainClock) disable iff (ClearCounter)
        $onehot0({bus.PcOut, bus.RamOut, bus.IrOut, bus.AccOut, bus.AluOut}));

endmodule

// File: doc/sap_control_sequencer.md
Name: sap_control_sequencer

Overview:
- Fetch/execute control sequencer for the 4-bit-PC SAP-style processor.
- Steps through T-states T1..T6 and decodes the 4-bit instruction opcode into the control word.
- The control word includes EnableCOunt/PcClear, which drive the 4-bit program counter, plus the MAR/RAM/IR/ACC/B/ALU/OUT strobes.
- Sits between the instruction register and every datapath register; it is the only source of PC increment and PC clear.

Parameters:
- OP_WIDTH, 4, opcode width taken from the IR upper nibble.
- OP_LDA, 4'b0000, load accumulator opcode.
- OP_ADD, 4'b0001, add opcode.
- OP_SUB, 4'b0010, subtract opcode.
- OP_OUT, 4'b1110, output opcode.
- OP_HLT, 4'b1111, halt opcode.

Ports:
- MainClock  in  1  single clock; all state changes on its rising edge.
- ClearCounter  in  1  synchronous active-high reset of the sequencer; forces IDLE.
- Start  in  1  level; sampled only in IDLE.
- Pause  in  1  level; freezes sequencing.
- IrOpcode  in  OP_WIDTH  opcode from the instruction register.
- PcClear  out  1  clear to the program counter.
- EnableCOunt  out  1  increment enable to the program counter.
- PcOut  out  1  PC drives bus.
- MarLoad  out  1  memory address register load.
- RamOut  out  1  RAM drives bus.
- IrLoad  out  1  instruction register load.
- IrOut  out  1  IR operand nibble drives bus.
- AccLoad  out  1  accumulator load.
- AccOut  out  1  accumulator drives bus.
- BLoad  out  1  B register load.
- AluSub  out  1  ALU subtract select.
- AluOut  out  1  ALU drives bus.
- OutLoad  out  1  output register load.
- Halt  out  1  processor halted.
- Busy  out  1  state is T1..T6.
- TState  out  3  current step: 0 = IDLE/HALTED, 1..6 = T1..T6.

Behaviour:
- Clock and reset: one clock, MainClock. Reset is synchronous and active-high on ClearCounter, sampled at the rising edge. While ClearCounter=1 the state goes to IDLE regardless of Start, Pause or the current state, including mid-instruction and HALTED.
- States: IDLE, T1, T2, T3, T4, T5, T6, HALTED. The state register is the only storage.
- All outputs are a combinational decode of the registered state, Pause and IrOpcode.
- Values in IDLE (also the post-reset values): PcClear=1; every other output 0; TState=0.
- Transitions:
  - IDLE -> T1 when Start=1, else stay in IDLE.
  - T1 -> T2 -> T3 -> T4.
  - T4 -> HALTED if IrOpcode==OP_HLT, else T4 -> T5.
  - T5 -> T6 -> T1.
  - HALTED stays in HALTED; only ClearCounter exits it.
- Fetch strobes (every instruction):
  - T1: PcOut, MarLoad.
  - T2: EnableCOunt (the PC increments at the T2->T3 edge).
  - T3: RamOut, IrLoad.
- Execute strobes (T4..T6; IrOpcode must be stable from T4 on):
  - LDA: T4 IrOut+MarLoad; T5 RamOut+AccLoad; T6 none.
  - ADD: T4 IrOut+MarLoad; T5 RamOut+BLoad; T6 AluOut+AccLoad.
  - SUB: same as ADD, with AluSub=1 in both T5 and T6.
  - OUT: T4 AccOut+OutLoad; T5, T6 none.
  - HLT: T4 no strobes.
  - Any other opcode: NOP, no strobes in T4..T6; takes the full 6 steps.
- HALTED: Halt=1, Busy=0, TState=0, all strobes 0, PcClear=0 (the PC value is preserved).
- Pause=1 in T1..T6:
  - The state holds.
  - All load and enable strobes are forced to 0: MarLoad, IrLoad, AccLoad, BLoad, OutLoad, EnableCOunt.
  - Bus-drive and AluSub outputs stay at their decoded values.
  - Busy stays 1 and TState shows the held step.
  - The sequence resumes at the same step on the cycle after Pause falls.
  - Pause has no effect in IDLE or HALTED.
- Start while in T1..T6 or HALTED is ignored.
- ClearCounter and Pause both high: reset wins.
- PC wrap from 15 to 0 is the counter's behaviour. The sequencer is unaware of it and keeps fetching.
- At most one bus driver is active in any state; this is an assertion-checked invariant.
- Instruction latency is 6 cycles. HLT takes 4 cycles to reach HALTED.

Decomposition:
- Package sap_ctrl_pkg: state enumeration with a 3-bit encoding, opcode constants, control-word bit indices, and a CTRL_WIDTH constant.
- One natural sub-module: sap_ctrl_decode, purely combinational, taking (state, IrOpcode, Pause) to the control word.
- The top level holds the state register and the next-state logic.

Test Plan:
- Reset pulse mid-T5 of ADD: the next cycle shows IDLE with PcClear=1, TState=0, all strobes 0; Start=1 then gives T1 with PcOut=1, MarLoad=1.
- Start with IrOpcode=OP_LDA held: over 6 cycles TState runs 1..6. EnableCOunt=1 only in T2. T4 shows IrOut+MarLoad, T5 RamOut+AccLoad, T6 none; the cycle after T6 shows TState=1.
- Opcode OP_SUB: T5 has RamOut, BLoad, AluSub=1; T6 has AluOut, AccLoad, AluSub=1. No cycle has two bus drivers.
- Opcode OP_HLT: after T4, Halt=1, Busy=0 and stays so for 20 cycles despite Start pulses; ClearCounter=1 returns to IDLE.
- Pause=1 for 3 cycles during T2: TState stays 2, EnableCOunt=0 throughout; after release, EnableCOunt=1 for exactly one cycle and T3 follows.
- Opcode 4'b0111 (undefined): T4..T6 have zero strobes, then T1. Sixteen back-to-back fetches give exactly 16 EnableCOunt pulses, i.e. the PC wraps 15->0.
